// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helpers.
// Used by both uart_rx and uart_tx so the two ends always agree on timing.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int uart_div(input int freq, input int rate);
        return freq / rate;
    endfunction

    function automatic int uart_half(input int freq, input int rate);
        return (freq / rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// INIT is the value both flops take in reset, so the output is defined from the first cycle.
module sync_2ff #(
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= INIT;
            q       <= INIT;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised start-bit detection, centre sampling, 1-cycle valid/error strobes.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around each centre, decisions one cycle later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ = 1_000_000,
    parameter int RATE = 9_600
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_rx,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_frame_err,
    output logic                      o_busy
);

    localparam int DIV  = uart_div(FREQ, RATE);
    localparam int HALF = uart_half(FREQ, RATE);
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(UART_DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_WAIT = HALF;
`else
    localparam int START_WAIT = HALF - 1;
`endif
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_WAIT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(UART_DATA_BITS - 1);

    if (DIV < 4) begin : g_div_check
        $fatal(1, "uart_rx: FREQ/RATE must be at least 4");
    end

    logic rxs;
    logic rxs_d1;
    logic bit_smp;

    uart_state_t              state_q, state_d;
    logic [CW-1:0]            baud_q, baud_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_d;
    logic                     valid_d, ferr_d;

    sync_2ff #(.INIT(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx),
        .q     (rxs)
    );

    // rxs_d1 doubles as the edge-detect history and the centre sample in majority mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxs_d1 <= 1'b1;
        else        rxs_d1 <= rxs;
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxs_d2 <= 1'b1;
        else        rxs_d2 <= rxs_d1;
    end

    assign bit_smp = (rxs_d2 & rxs_d1) | (rxs_d2 & rxs) | (rxs_d1 & rxs);
`else
    assign bit_smp = rxs;
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = o_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (rxs_d1 && !rxs) begin
                    state_d = START;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_q == START_LAST) begin
                    baud_d  = '0;
                    state_d = bit_smp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_q == DIV_LAST) begin
                    baud_d  = '0;
                    shift_d = {bit_smp, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (baud_q == DIV_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (bit_smp) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            o_data      <= data_d;
            o_valid     <= valid_d;
            o_frame_err <= ferr_d;
        end
    end

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default FREQ/RATE (DIV=104, HALF=52).
// Frames are driven bit by bit; a negedge monitor counts valid/error strobes.
module tb_uart_rx;

    localparam int DIV  = 104;
    localparam int HALF = 52;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT         = HALF + 9 * DIV + 4;
    localparam logic [7:0] GLT = 8'hF0;
`else
    localparam int LAT         = HALF + 9 * DIV + 3;
    localparam logic [7:0] GLT = 8'h0F;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    uart_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;
    logic [7:0] vlog[$];
    int         vcyc[$];

    always @(negedge clk) begin
        if (o_valid) begin
            n_valid++;
            vlog.push_back(o_data);
            vcyc.push_back(cyc);
        end
        if (o_frame_err) n_ferr++;
        if (o_valid && o_frame_err) n_both++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int t_start  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            #1;
            i_rx = (glitch && c == HALF) ? ~b : b;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
        for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) t_start = cyc;
            i_rx = 1'b0;
        end
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(stop, 1'b0);
        @(posedge clk);
        #1;
        i_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int nv0, nf0, q0;

        tbl[0] = '{8'h6A, 1'b1, 1'b0, 1, 0, 8'h6A};
        tbl[1] = '{8'h55, 1'b0, 1'b0, 0, 1, 8'h6A};
        tbl[2] = '{8'hF0, 1'b1, 1'b1, 1, 0, GLT};

        rst_n = 1'b0;
        i_rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ferr", o_frame_err, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 3; i++) begin
            nv0 = n_valid;
            nf0 = n_ferr;
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].glitch);
            idle(10);
            chk($sformatf("tbl%0d_valid", i), n_valid - nv0, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_ferr", i), n_ferr - nf0, tbl[i].exp_ferr);
            chk($sformatf("tbl%0d_data", i), o_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_busy", i), o_busy, 1'b0);
            if (i == 0 && vcyc.size() > 0)
                chk_rng("latency", vcyc[vcyc.size()-1] - t_start, LAT - 1, LAT + 1);
        end

        // back-to-back frames, no idle between stop and next start
        q0 = vlog.size();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(10);
        chk("b2b_count", vlog.size() - q0, 2);
        if (vlog.size() - q0 == 2) begin
            chk("b2b_first", vlog[q0], 8'h00);
            chk("b2b_second", vlog[q0+1], 8'hFF);
            chk_rng("b2b_spacing", vcyc[q0+1] - vcyc[q0], 10 * DIV - 1, 10 * DIV + 1);
        end

        // short low pulse: start sample reads 1, frame abandoned
        nv0 = n_valid;
        nf0 = n_ferr;
        @(posedge clk);
        #1;
        i_rx = 1'b0;
        idle(10);
        chk("glitch_busy_hi", o_busy, 1'b1);
        idle(10);
        i_rx = 1'b1;
        idle(60);
        chk("glitch_busy_lo", o_busy, 1'b0);
        chk("glitch_valid", n_valid - nv0, 0);
        chk("glitch_ferr", n_ferr - nf0, 0);

        // reset in the middle of the data bits of 8'hA5
        nv0 = n_valid;
        nf0 = n_ferr;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("mid_busy", o_busy, 1'b1);
        i_rx  = 1'b1;
        rst_n = 1'b0;
        idle(3);
        chk("mid_rst_data", o_data, 8'h00);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_ferr", o_frame_err, 1'b0);
        chk("mid_rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        idle(2 * DIV);
        chk("mid_no_valid", n_valid - nv0, 0);
        chk("mid_no_ferr", n_ferr - nf0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        chk("after_rst_valid", n_valid - nv0, 1);
        chk("after_rst_data", o_data, 8'h3C);

        chk("never_both", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
